// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register command path: header codes,
// millisecond tick count, arbiter state encoding and the command word layout.
package uart_reg_pkg;

  localparam logic [15:0] DELAY_HEADER = 16'habcd;
  localparam logic [15:0] WAIT_HEADER  = 16'habc1;
  localparam int unsigned MS_CNT       = 50_000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [15:0] header;
    logic [15:0] payload;
  } cmd_word_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin first-one finder: one-hot pick of the first request at or after
// rr_ptr_i, wrapping around.
module uart_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] rr_ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          any_o
);

  logic found;
  int   idx;

  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(rr_ptr_i) + off) % N;
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_reg_cmd_arbiter.sv
// Packet-locked round-robin arbiter feeding the register delay queue, with
// credit-based occupancy tracking and a stall timeout on the lock.
module uart_reg_cmd_arbiter
  import uart_reg_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int LOCK_TO    = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [32*NUM_REQ-1:0]           req_data,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [31:0]                     reg_in,
  output logic                            reg_valid,
  input  logic                            reg_ready,
  output logic [NUM_REQ-1:0]              grant,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] credit_used,
  output logic [1:0]                      err_flags
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(LOCK_TO + 1);

  arb_state_e       state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [CW-1:0]    credit_q, credit_d;
  logic [SW-1:0]    stall_q;
  cmd_word_t        reg_in_q;
  logic             reg_valid_q;
  logic [1:0]       err_q;

  logic [NUM_REQ-1:0] pick;
  logic             pick_any;
  logic [PW-1:0]    owner, next_ptr;
  logic             owner_valid, owner_last, credit_ok, accept, underflow;
  logic [31:0]      owner_data;

  uart_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick),
    .any_o    (pick_any)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q[i]) owner = PW'(i);
  end

  assign owner_valid = req_valid[owner];
  assign owner_last  = req_last[owner];
  assign owner_data  = req_data[32*int'(owner) +: 32];
  assign next_ptr    = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign credit_ok   = credit_q < CW'(FIFO_DEPTH);
  assign req_ready   = (state_q == S_XFER && credit_ok) ? (grant_q & req_valid) : '0;
  assign accept      = |req_ready;
  assign underflow   = reg_ready && !accept && credit_q == '0;

  // A push and a queue pop in the same cycle cancel out.
  always_comb begin
    credit_d = credit_q;
    if (accept && !reg_ready)
      credit_d = credit_q + 1'b1;
    else if (!accept && reg_ready && credit_q != '0)
      credit_d = credit_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      credit_q    <= '0;
      stall_q     <= '0;
      reg_in_q    <= '0;
      reg_valid_q <= 1'b0;
      err_q       <= '0;
    end else begin
      credit_q    <= credit_d;
      reg_valid_q <= accept;
      if (underflow) err_q[0] <= 1'b1;
      if (accept) reg_in_q <= owner_data;
      case (state_q)
        S_IDLE: begin
          if (pick_any && credit_ok) begin
            grant_q <= pick;
            stall_q <= '0;
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (accept) begin
            stall_q <= '0;
            if (owner_last) begin
              state_q  <= S_IDLE;
              grant_q  <= '0;
              rr_ptr_q <= next_ptr;
            end
          end else if (!owner_valid) begin
            // Only source-side stalls count; a full queue is not the owner's fault.
            if (stall_q == SW'(LOCK_TO - 1)) begin
              state_q  <= S_IDLE;
              grant_q  <= '0;
              rr_ptr_q <= next_ptr;
              stall_q  <= '0;
              err_q[1] <= 1'b1;
            end else begin
              stall_q <= stall_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign reg_in      = reg_in_q;
  assign reg_valid   = reg_valid_q;
  assign credit_used = credit_q;
  assign err_flags   = err_q;

endmodule

// File: tb/tb_uart_reg_cmd_arbiter.sv
// Directed bench for uart_reg_cmd_arbiter: a per-cycle vector table for a
// single packet, plus hand sequences for contention, full queue, reset and lock timeout.
module tb_uart_reg_cmd_arbiter;
  import uart_reg_pkg::*;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int LT = 8;
  localparam int CW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_valid, req_last, req_ready, grant;
  logic [31:0]     reg_in;
  logic            reg_valid, reg_ready;
  logic [CW-1:0]   credit_used;
  logic [1:0]      err_flags;

  always #5 clk = ~clk;

  uart_reg_cmd_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(D), .LOCK_TO(LT)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .reg_in(reg_in),
    .reg_valid(reg_valid), .reg_ready(reg_ready), .grant(grant),
    .credit_used(credit_used), .err_flags(err_flags)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Requester models: each replays a word list, optionally going silent at pause index.
  logic [31:0] srcw [N][8];
  int          src_len [N];
  int          src_pos [N];
  int          src_pause [N];
  bit          src_en [N];
  bit          src_mode = 1'b0;
  bit          auto_drain = 1'b0;
  logic [N-1:0] acc_s = '0;
  int          cyc = 0;
  logic [31:0] push_q [$];
  int          push_cyc [$];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] mkword(input int i, input int k, input int tag);
    logic [15:0] hdr;
    hdr = (k == 0) ? ((i == 0) ? DELAY_HEADER : WAIT_HEADER) : 16'(16'h1000 + i);
    return {hdr, 8'(tag), 8'(k)};
  endfunction

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      int p;
      p = src_pos[i];
      req_valid[i] = src_en[i] && p < src_len[i] && p != src_pause[i];
      req_data[32*i +: 32] = srcw[i][(p < 8) ? p : 7];
      req_last[i] = (p == src_len[i] - 1);
    end
  endtask

  task automatic load_src(input int i, input int len, input int pause, input int tag);
    for (int k = 0; k < 8; k++) srcw[i][k] = (k < len) ? mkword(i, k, tag) : 32'h0;
    src_len[i]   = len;
    src_pos[i]   = 0;
    src_pause[i] = pause;
    src_en[i]    = 1'b1;
    drive_src();
  endtask

  always @(negedge clk) begin
    acc_s = req_valid & req_ready;
    if (reg_valid) begin
      push_q.push_back(reg_in);
      push_cyc.push_back(cyc);
    end
    if (auto_drain) reg_ready = reg_valid;
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    if (src_mode) begin
      for (int i = 0; i < N; i++) if (acc_s[i]) src_pos[i]++;
      drive_src();
    end
  end

  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    push_q.delete();
    push_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    at_edge();
    rst = 1'b1;
    at_edge();
    rst = 1'b0;
    for (int i = 0; i < N; i++) src_en[i] = 1'b0;
    if (src_mode) drive_src();
    clear_q();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_reg_in"},    reg_in, 32'h0);
    check({tag, "_reg_valid"}, 32'(reg_valid), 32'h0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_grant"},     32'(grant), 32'h0);
    check({tag, "_credit"},    32'(credit_used), 32'h0);
    check({tag, "_err"},       32'(err_flags), 32'h0);
  endtask

  task automatic wait_pushes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (push_q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_push_count"}, 32'(push_q.size()), 32'(n));
  endtask

  task automatic run_contention(input string tag, input int first, input int tag_id);
    clear_q();
    at_edge();
    load_src(0, 3, -1, tag_id);
    load_src(1, 3, -1, tag_id);
    for (int k = 0; k < 3; k++) exp_q.push_back(mkword(first, k, tag_id));
    for (int k = 0; k < 3; k++) exp_q.push_back(mkword(1 - first, k, tag_id));
    wait_pushes(tag, 6, 40);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s_word%0d", tag, k),
            (k < push_q.size()) ? push_q[k] : 32'hxxxxxxxx, exp_q[k]);
  endtask

  typedef struct {
    logic [1:0]    v;
    logic [1:0]    l;
    logic [31:0]   d0;
    logic          rr;
    logic [1:0]    ex_rdy;
    logic [1:0]    ex_gnt;
    logic          ex_rv;
    logic [31:0]   ex_in;
    logic [CW-1:0] ex_cr;
  } vec_t;

  vec_t tv [7];

  initial begin
    tv[0] = '{2'b01, 2'b00, 32'habcd0005, 1'b0, 2'b00, 2'b00, 1'b0, 32'h00000000, 3'd0};
    tv[1] = '{2'b01, 2'b00, 32'habcd0005, 1'b0, 2'b01, 2'b01, 1'b0, 32'h00000000, 3'd0};
    tv[2] = '{2'b01, 2'b01, 32'h00120034, 1'b0, 2'b01, 2'b01, 1'b1, 32'habcd0005, 3'd1};
    tv[3] = '{2'b00, 2'b00, 32'h00000000, 1'b0, 2'b00, 2'b00, 1'b1, 32'h00120034, 3'd2};
    tv[4] = '{2'b00, 2'b00, 32'h00000000, 1'b1, 2'b00, 2'b00, 1'b0, 32'h00120034, 3'd2};
    tv[5] = '{2'b00, 2'b00, 32'h00000000, 1'b1, 2'b00, 2'b00, 1'b0, 32'h00120034, 3'd1};
    tv[6] = '{2'b00, 2'b00, 32'h00000000, 1'b0, 2'b00, 2'b00, 1'b0, 32'h00120034, 3'd0};

    rst = 1'b1;
    req_data = '0;
    req_valid = '0;
    req_last = '0;
    reg_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0; src_pos[i] = 0; src_pause[i] = -1; src_en[i] = 1'b0;
    end

    at_edge();
    at_edge();
    @(negedge clk);
    check_reset("rst");
    at_edge();
    rst = 1'b0;

    // Single packet from requester 0, cycle by cycle.
    for (int k = 0; k < 7; k++) begin
      req_valid = tv[k].v;
      req_last  = tv[k].l;
      req_data  = {32'h0, tv[k].d0};
      reg_ready = tv[k].rr;
      @(negedge clk);
      check($sformatf("pkt_c%0d_ready", k),  32'(req_ready),   32'(tv[k].ex_rdy));
      check($sformatf("pkt_c%0d_grant", k),  32'(grant),       32'(tv[k].ex_gnt));
      check($sformatf("pkt_c%0d_rvalid", k), 32'(reg_valid),   32'(tv[k].ex_rv));
      check($sformatf("pkt_c%0d_reg_in", k), reg_in,           tv[k].ex_in);
      check($sformatf("pkt_c%0d_credit", k), 32'(credit_used), 32'(tv[k].ex_cr));
      at_edge();
    end
    reg_ready = 1'b0;

    // Requester 0 owned last, so requester 1 wins the next contention.
    src_mode   = 1'b1;
    auto_drain = 1'b1;
    drive_src();
    run_contention("cont_after_r0", 1, 1);

    // From reset requester 0 goes first; one bubble between packets.
    do_reset();
    run_contention("cont_reset", 0, 2);
    check("cont_b2b_gap", 32'((push_cyc.size() > 1) ? push_cyc[1] - push_cyc[0] : -1), 32'd1);
    check("cont_bubble_gap", 32'((push_cyc.size() > 3) ? push_cyc[3] - push_cyc[2] : -1), 32'd2);
    run_contention("cont_after_r1", 0, 3);
    check("cont_err", 32'(err_flags), 32'h0);

    // Full queue with no drain.
    do_reset();
    auto_drain = 1'b0;
    reg_ready  = 1'b0;
    load_src(0, 6, -1, 4);
    repeat (12) @(negedge clk);
    #1;
    check("full_pushes", 32'(push_q.size()), 32'd4);
    check("full_credit", 32'(credit_used), 32'd4);
    check("full_ready", 32'(req_ready), 32'h0);
    check("full_grant", 32'(grant), 32'h1);
    at_edge();
    reg_ready = 1'b1;
    at_edge();
    reg_ready = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("full_one_more_pushes", 32'(push_q.size()), 32'd5);
    check("full_one_more_credit", 32'(credit_used), 32'd4);

    // Pop brings credit to 3, then pop plus push in one cycle holds it at 3.
    at_edge();
    reg_ready = 1'b1;
    at_edge();
    @(negedge clk);
    check("simul_credit_before", 32'(credit_used), 32'd3);
    check("simul_ready", 32'(req_ready), 32'h1);
    at_edge();
    reg_ready = 1'b0;
    @(negedge clk);
    check("simul_credit_after", 32'(credit_used), 32'd3);
    repeat (2) @(negedge clk);
    #1;
    check("simul_pushes", 32'(push_q.size()), 32'd6);
    at_edge();
    reg_ready = 1'b1;
    repeat (3) at_edge();
    reg_ready = 1'b0;
    @(negedge clk);
    check("drain_credit", 32'(credit_used), 32'd0);
    check("drain_err", 32'(err_flags), 32'h0);
    at_edge();
    reg_ready = 1'b1;
    at_edge();
    reg_ready = 1'b0;
    @(negedge clk);
    check("underflow_credit", 32'(credit_used), 32'd0);
    check("underflow_err", 32'(err_flags), 32'h1);

    // Reset in the middle of a packet.
    auto_drain = 1'b1;
    at_edge();
    load_src(0, 3, -1, 5);
    @(negedge clk);
    @(negedge clk);
    check("midrst_grant_before", 32'(grant), 32'h1);
    check("midrst_ready_before", 32'(req_ready), 32'h1);
    at_edge();
    rst = 1'b1;
    at_edge();
    rst = 1'b0;
    load_src(0, 3, -1, 5);
    @(negedge clk);
    check_reset("midrst");
    @(negedge clk);
    check("midrst_regrant", 32'(grant), 32'h1);
    check("midrst_ready_after", 32'(req_ready), 32'h1);
    repeat (6) @(negedge clk);

    // Lock timeout: owner goes silent after two words, requester 1 waits.
    do_reset();
    load_src(0, 4, 2, 6);
    load_src(1, 2, -1, 6);
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("lock_grant_held", 32'(grant), 32'h1);
    check("lock_err_clear", 32'(err_flags), 32'h0);
    @(negedge clk);
    check("lock_grant_released", 32'(grant), 32'h0);
    check("lock_err_set", 32'(err_flags), 32'h2);
    @(negedge clk);
    check("lock_next_grant", 32'(grant), 32'h2);
    repeat (5) @(negedge clk);
    #1;
    check("lock_pushes", 32'(push_q.size()), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
